// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, sample type and averaging-filter FSM states.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {CLEAR, RUN} avg_state_t;

endpackage

// File: rtl/avg_sample_ring.sv
// N-entry sample store for the moving-average window.
// There is no reset here; the parent zero-fills it after reset.
module avg_sample_ring #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    // Single write port; the read is combinational so the oldest sample is available on accept.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/audio_avg_filter.sv
// Single-channel moving-average filter over the last 2**LOG2_N accepted samples.
// Each sample is pre-scaled by 1/N, so the running sum is directly the mean.
module audio_avg_filter
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W = SAMPLE_W,
    parameter int unsigned LOG2_N = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    localparam logic [LOG2_N-1:0] IdxOne = LOG2_N'(1);

    avg_state_t        state_q, state_d;
    logic [LOG2_N-1:0] clr_cnt_q, clr_cnt_d;
    logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic signed [DATA_W-1:0] in_s;
    logic [DATA_W-1:0]        scaled;
    logic [DATA_W-1:0]        oldest;
    logic [DATA_W-1:0]        acc_next;
    logic                     accept;
    logic                     ring_we;
    logic [LOG2_N-1:0]        ring_waddr;
    logic [DATA_W-1:0]        ring_wdata;

    assign in_s     = in_data_i;
    assign scaled   = in_s >>> LOG2_N;
    assign acc_next = acc_q + scaled - oldest;

    // A stalled output blocks input so a computed result is never overwritten.
    assign in_ready_o = (state_q == RUN) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // During CLEAR the ring port sweeps all entries writing zero.
    assign ring_we    = (state_q == CLEAR) || accept;
    assign ring_waddr = (state_q == CLEAR) ? clr_cnt_q : wr_ptr_q;
    assign ring_wdata = (state_q == CLEAR) ? '0 : scaled;

    avg_sample_ring #(
        .DATA_W (DATA_W),
        .ADDR_W (LOG2_N)
    ) u_ring (
        .clk_i   (clk_i),
        .we_i    (ring_we),
        .waddr_i (ring_waddr),
        .wdata_i (ring_wdata),
        .raddr_i (wr_ptr_q),
        .rdata_o (oldest)
    );

    // Next-state: clear sweep, then accept/consume handshakes in RUN.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + IdxOne;
                if (clr_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    wr_ptr_d    = wr_ptr_q + IdxOne;
                    acc_d       = acc_next;
                    out_data_d  = acc_next;
                    out_valid_d = 1'b1;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Bench for audio_avg_filter (N=8, 24-bit): scoreboard of expected means, checked on output.
module tb_audio_avg_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [23:0] out_data_o;

    int checks = 0;
    int errors = 0;

    int          hist[$];
    logic [23:0] sb[$];

    audio_avg_filter #(
        .DATA_W (24),
        .LOG2_N (3)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_o)
    );

    always #5 clk = ~clk;

    // Reference: mean = sum of the last 8 (x >>> 3), zero-filled window.
    function automatic logic [23:0] model_accept(input logic [23:0] d);
        int s;
        int sum;
        s = int'($signed(d)) >>> 3;
        hist.push_back(s);
        if (hist.size() > 8) void'(hist.pop_front());
        sum = 0;
        foreach (hist[k]) sum += hist[k];
        return sum[23:0];
    endfunction

    function automatic logic [23:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        hist.delete(); sb.delete();
        for (int i = 0; i < 20 && !in_ready_o; i++) @(negedge clk);
        checks++;
        if (!in_ready_o) begin
            errors++;
            $display("FAIL reset_ready_timeout: in_ready=%b expected 1", in_ready_o);
        end
    endtask

    task automatic test_reset();
        int cnt;
        bit seen_valid;
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        hist.delete(); sb.delete();
        cnt = 0; seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (out_valid_o !== 1'b0 || out_data_o !== 24'h0) begin
                    errors++;
                    $display("FAIL reset_outputs: valid=%b data=%h expected 0/000000",
                             out_valid_o, out_data_o);
                end
            end
            if (out_valid_o !== 1'b0) seen_valid = 1;
            if (in_ready_o === 1'b1) break;
            cnt++;
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL reset_clear_cycles: got %0d expected 8", cnt);
        end
        @(negedge clk);
        if (out_valid_o !== 1'b0) seen_valid = 1;
        checks++;
        if (seen_valid || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: out_valid_seen=%0d in_ready=%b expected 0/1",
                     seen_valid, in_ready_o);
        end
    endtask

    task automatic test_step();
        logic [23:0] e;
        apply_reset();
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 12); in_data = 24'h080000; out_ready = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL step_latency[%0d]: out_valid=%b expected 1", i, out_valid_o);
                end
            end
            if (out_valid_o && out_ready) begin
                e = sb_pop();
                checks++;
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL step_data[%0d]: got %h expected %h", i, out_data_o, e);
                end
                checks++;
                if (out_data_o !== 24'(((i < 8) ? i : 8) * 24'h010000)) begin
                    errors++;
                    $display("FAIL step_const[%0d]: got %h expected %h", i, out_data_o,
                             24'(((i < 8) ? i : 8) * 24'h010000));
                end
            end
            if (in_valid) sb.push_back(model_accept(in_data));
        end
    endtask

    task automatic test_negative();
        logic [23:0] e;
        apply_reset();
        for (int i = 0; i <= 9; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 9); in_data = (i < 8) ? 24'hFFFFF8 : 24'h000007; out_ready = 1'b1;
            @(negedge clk);
            if (out_valid_o && out_ready) begin
                e = sb_pop();
                checks++;
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL neg_data[%0d]: got %h expected %h", i, out_data_o, e);
                end
            end
            if (i == 8 || i == 9) begin
                checks++;
                if (out_data_o !== ((i == 8) ? 24'hFFFFF8 : 24'hFFFFF9)) begin
                    errors++;
                    $display("FAIL neg_const[%0d]: got %h expected %h", i, out_data_o,
                             (i == 8) ? 24'hFFFFF8 : 24'hFFFFF9);
                end
            end
            if (in_valid) sb.push_back(model_accept(in_data));
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] e;
        logic        exp_valid;
        logic        exp_ready;
        int          pops;
        apply_reset();
        exp_valid = 0; pops = 0;
        for (int i = 0; i <= 9; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 9); in_data = 24'h080000; out_ready = !(i >= 1 && i <= 5);
            @(negedge clk);
            exp_ready = !exp_valid || out_ready;
            if (!out_ready) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== 24'h010000 || in_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b expected 1/010000/0",
                             i, out_valid_o, out_data_o, in_ready_o);
                end
            end
            if (exp_valid && out_ready) begin
                e = sb_pop();
                pops++;
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== e) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: valid=%b data=%h expected 1/%h",
                             i, out_valid_o, out_data_o, e);
                end
                if (pops == 2) begin
                    checks++;
                    if (out_data_o !== 24'h020000) begin
                        errors++;
                        $display("FAIL bp_release: got %h expected 020000", out_data_o);
                    end
                end
            end
            if (in_valid && exp_ready) begin
                sb.push_back(model_accept(in_data));
                exp_valid = 1;
            end else if (out_ready) begin
                exp_valid = 0;
            end
        end
    endtask

    task automatic test_wrap();
        logic [23:0] e;
        apply_reset();
        for (int i = 0; i <= 24; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 24); in_data = (i < 16) ? 24'h080000 : 24'h000000; out_ready = 1'b1;
            @(negedge clk);
            if (out_valid_o && out_ready) begin
                e = sb_pop();
                checks++;
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: got %h expected %h", i, out_data_o, e);
                end
            end
            if (in_valid) sb.push_back(model_accept(in_data));
        end
        checks++;
        if (out_data_o !== 24'h000000 || sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_final: got %h (pending %0d) expected 000000 (0)",
                     out_data_o, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [23:0] e;
        int          cnt;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 24'h080000; out_ready = 1'b1;
            @(negedge clk);
            if (out_valid_o && out_ready) e = sb_pop();
            sb.push_back(model_accept(in_data));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 24'h050000) begin
            errors++;
            $display("FAIL mid_pre: valid=%b data=%h expected 1/050000", out_valid_o, out_data_o);
        end
        reset = 1'b1; in_valid = 1'b1; in_data = 24'h7FFFF8;
        @(posedge clk); #1;
        reset = 1'b0;
        hist.delete(); sb.delete();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (out_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_discard: out_valid=%b expected 0", out_valid_o);
                end
            end
            if (in_ready_o === 1'b1) break;
            cnt++;
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL mid_clear_cycles: got %0d expected 8", cnt);
        end
        in_data = 24'h080000;
        sb.push_back(model_accept(in_data));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        e = sb_pop();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== e || out_data_o !== 24'h010000) begin
            errors++;
            $display("FAIL mid_first: valid=%b data=%h expected 1/010000", out_valid_o, out_data_o);
        end
    endtask

    task automatic test_random();
        logic [23:0] e;
        logic        exp_valid;
        logic        exp_ready;
        apply_reset();
        exp_valid = 0;
        for (int i = 0; i < 304; i++) begin
            @(posedge clk); #1;
            if (i < 300) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 24'($urandom());
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            exp_ready = !exp_valid || out_ready;
            checks++;
            if (in_ready_o !== exp_ready || out_valid_o !== exp_valid) begin
                errors++;
                $display("FAIL rand_hs[%0d]: ready=%b valid=%b expected %b/%b",
                         i, in_ready_o, out_valid_o, exp_ready, exp_valid);
            end
            if (exp_valid && out_ready) begin
                e = sb_pop();
                checks++;
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", i, out_data_o, e);
                end
            end
            if (in_valid && exp_ready) begin
                sb.push_back(model_accept(in_data));
                exp_valid = 1;
            end else if (out_ready) begin
                exp_valid = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_negative();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
